// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding and default widths for the data-memory stage.
// Imported by dmem_wbuf and dmem_stage_ctrl.
package dmem_pkg;

    localparam int DEF_DATA_W     = 16;
    localparam int DEF_ADDR_W     = 16;
    localparam int DEF_WBUF_DEPTH = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LOAD_RSP,
        S_STORE,
        S_DRAIN,
        S_DUMP,
        S_HALTED
    } state_t;

    // States in which the buffer head is on the memory write port.
    function automatic logic is_wr_state(input state_t s);
        return (s == S_STORE) || (s == S_DRAIN);
    endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// dmem_wbuf: circular posted-store buffer; with DMEM_WBUF_FWD_EN defined it
// also CAM-compares a load address against every valid entry.
module dmem_wbuf
    import dmem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
`ifdef DMEM_WBUF_FWD_EN
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              fwd_hit,
    output logic [DATA_W-1:0] fwd_data,
`endif
    output logic [ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= push_addr;
            data_mem[tail] <= push_data;
        end
    end

    assign head_addr = addr_mem[head];
    assign head_data = data_mem[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

`ifdef DMEM_WBUF_FWD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (addr_mem[idx] == lookup_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[idx];
            end
        end
    end
`endif

endmodule

// File: rtl/dmem_stage_ctrl.sv
// dmem_stage_ctrl: MEM-stage controller with posted stores and one load.
// Define DMEM_WBUF_FWD_EN to forward buffered store data to loads.
module dmem_stage_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int WBUF_DEPTH = DEF_WBUF_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_rd,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic              halt_req,
    output logic              stall_out,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_done,
    input  logic              mem_err,
    output logic              dump_out,
    output logic              halt_out,
    output logic              err_out
);

    state_t            state;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic [DATA_W-1:0] rdata_q;
    logic              load_ok;
    logic              load_issue;
    logic              fwd_now;

`ifdef DMEM_WBUF_FWD_EN
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;

    dmem_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_addr   (req_addr),
        .push_data   (req_wdata),
        .pop         (pop),
        .lookup_addr (req_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data),
        .head_addr   (head_addr),
        .head_data   (head_data),
        .full        (full),
        .empty       (empty)
    );

    // A hit completes from the buffer; a miss may bypass older stores.
    assign fwd_now     = (state == S_IDLE) & req_rd & ~halt_out & fwd_hit;
    assign load_ok     = ~fwd_hit;
    assign rdata       = fwd_now ? fwd_data : rdata_q;
    assign rdata_valid = (state == S_LOAD_RSP) | fwd_now;
`else
    dmem_wbuf #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (WBUF_DEPTH)
    ) u_wbuf (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_addr (req_addr),
        .push_data (req_wdata),
        .pop       (pop),
        .head_addr (head_addr),
        .head_data (head_data),
        .full      (full),
        .empty     (empty)
    );

    // Loads wait for every older store to reach memory.
    assign fwd_now     = 1'b0;
    assign load_ok     = empty;
    assign rdata       = rdata_q;
    assign rdata_valid = (state == S_LOAD_RSP);
`endif

    assign load_issue = (state == S_IDLE) & req_rd & ~halt_out & load_ok;

    assign stall_out = ~halt_out & (
                           (req_rd & (state != S_LOAD_RSP) & ~fwd_now)
                         | (req_wr & full)
                         | halt_req);

    assign push = req_wr & ~stall_out & ~halt_out;
    assign pop  = is_wr_state(state) & mem_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
            dump_out  <= 1'b0;
            halt_out  <= 1'b0;
            err_out   <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (load_issue) begin
                        state    <= S_LOAD;
                        mem_rd   <= 1'b1;
                        mem_addr <= req_addr;
                    end else if (!empty) begin
                        state     <= halt_req ? S_DRAIN : S_STORE;
                        mem_wr    <= 1'b1;
                        mem_addr  <= head_addr;
                        mem_wdata <= head_data;
                    end else if (halt_req) begin
                        state    <= S_DUMP;
                        dump_out <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (mem_done) begin
                        mem_rd  <= 1'b0;
                        rdata_q <= mem_rdata;
                        state   <= S_LOAD_RSP;
                        if (mem_err) begin
                            err_out  <= 1'b1;
                            halt_out <= 1'b1;
                        end
                    end
                end
                S_LOAD_RSP: begin
                    state <= err_out ? S_HALTED : S_IDLE;
                end
                S_STORE, S_DRAIN: begin
                    // IDLE re-arbitrates: next store, next drain step or dump.
                    if (mem_done) begin
                        mem_wr <= 1'b0;
                        if (mem_err) begin
                            err_out  <= 1'b1;
                            halt_out <= 1'b1;
                            state    <= S_HALTED;
                        end else begin
                            state <= S_IDLE;
                        end
                    end
                end
                S_DUMP: begin
                    dump_out <= 1'b0;
                    halt_out <= 1'b1;
                    state    <= S_HALTED;
                end
                S_HALTED: begin
                    state <= S_HALTED;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_stage_ctrl.sv
// tb_dmem_stage_ctrl: directed stimulus with queue scoreboard and a
// variable-latency memory responder for dmem_stage_ctrl.
module tb_dmem_stage_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd;
    logic        req_wr;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        halt_req;
    logic        stall_out;
    logic [15:0] rdata;
    logic        rdata_valid;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_done;
    logic        mem_err;
    logic        dump_out;
    logic        halt_out;
    logic        err_out;

    int          checks   = 0;
    int          failures = 0;
    int          dump_cnt = 0;
    int          lat      = 2;
    logic        err_next = 1'b0;

    logic [31:0] exp_wr [$];
    logic [15:0] exp_rd [$];
    logic [15:0] exp_ra [$];
    logic [15:0] mem_model [logic [15:0]];

    always #5 clk = ~clk;

    dmem_stage_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .req_rd      (req_rd),
        .req_wr      (req_wr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .halt_req    (halt_req),
        .stall_out   (stall_out),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .mem_rd      (mem_rd),
        .mem_wr      (mem_wr),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_done    (mem_done),
        .mem_err     (mem_err),
        .dump_out    (dump_out),
        .halt_out    (halt_out),
        .err_out     (err_out)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=event required=none", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory: done after `lat` cycles of a held strobe.
    initial begin : responder
        int busy = 0;
        mem_done  = 1'b0;
        mem_err   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_done = 1'b0;
            mem_err  = 1'b0;
            if (rst || !(mem_rd || mem_wr)) begin
                busy = 0;
            end else begin
                busy++;
                if (busy >= lat) begin
                    busy     = 0;
                    mem_done = 1'b1;
                    mem_err  = err_next;
                    err_next = 1'b0;
                    if (mem_wr) begin
                        mem_model[mem_addr] = mem_wdata;
                    end else if (mem_model.exists(mem_addr)) begin
                        mem_rdata = mem_model[mem_addr];
                    end else begin
                        mem_rdata = 16'h0000;
                    end
                end
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            assert (!(req_rd && req_wr))
            else $error("FAIL req_exclusive actual=both required=one");
            if (dump_out) dump_cnt++;
            if (rdata_valid) begin
                if (exp_rd.size() == 0) unexpected("rdata_valid");
                else check("rdata", rdata, exp_rd.pop_front());
            end
            if (mem_done && mem_wr) begin
                if (exp_wr.size() == 0) begin
                    unexpected("mem_write");
                end else begin
                    e = exp_wr.pop_front();
                    check("mem_wr_addr", mem_addr, e[31:16]);
                    check("mem_wr_data", mem_wdata, e[15:0]);
                end
            end
            if (mem_done && mem_rd) begin
                if (exp_ra.size() == 0) unexpected("mem_read");
                else check("mem_rd_addr", mem_addr, exp_ra.pop_front());
            end
        end
    end

    task automatic reset_and_check(input string tag);
        rst       = 1'b1;
        req_rd    = 1'b0;
        req_wr    = 1'b0;
        halt_req  = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        exp_wr.delete();
        exp_rd.delete();
        exp_ra.delete();
        tick();
        @(negedge clk);
        check({tag, "_stall"}, stall_out, 0);
        check({tag, "_rvalid"}, rdata_valid, 0);
        check({tag, "_rdata"}, rdata, 0);
        check({tag, "_mem_rd"}, mem_rd, 0);
        check({tag, "_mem_wr"}, mem_wr, 0);
        check({tag, "_dump"}, dump_out, 0);
        check({tag, "_halt"}, halt_out, 0);
        check({tag, "_err"}, err_out, 0);
        tick();
        rst      = 1'b0;
        err_next = 1'b0;
    endtask

    task automatic do_store(input logic [15:0] a, input logic [15:0] d,
                            input bit expect_write, output int stalls);
        req_wr    = 1'b1;
        req_addr  = a;
        req_wdata = d;
        stalls    = 0;
        if (expect_write) exp_wr.push_back({a, d});
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stall_out) begin
                tick();
                req_wr = 1'b0;
                return;
            end
            stalls++;
            tick();
        end
        req_wr = 1'b0;
        unexpected("store_accept_timeout");
    endtask

    task automatic present_load(input logic [15:0] a, input bit via_mem,
                                input logic [15:0] d,
                                output int stalls, output int done_at);
        req_rd   = 1'b1;
        req_addr = a;
        stalls   = 0;
        done_at  = 0;
        exp_rd.push_back(d);
        if (via_mem) exp_ra.push_back(a);
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (rdata_valid) begin
                done_at = c;
                break;
            end
            if (stall_out) stalls++;
            tick();
        end
        tick();
        req_rd = 1'b0;
    endtask

    task automatic do_halt(output int cyc, output int unstalled);
        halt_req  = 1'b1;
        cyc       = 0;
        unstalled = 0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (halt_out) begin
                cyc = c;
                break;
            end
            if (!stall_out) unstalled++;
            tick();
        end
        tick();
        halt_req = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int c = 0; c < 200; c++) begin
            if (exp_wr.size() == 0 && exp_rd.size() == 0 && exp_ra.size() == 0)
                break;
            tick();
        end
        check({tag, "_drained"}, exp_wr.size() + exp_rd.size() + exp_ra.size(), 0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int st;
        int dn;
        int cyc;
        int un;
        int d0;
        int s [5];

        reset_and_check("rst0");

        // Single load, memory latency 3.
        lat = 3;
        mem_model[16'h0010] = 16'hBEEF;
        present_load(16'h0010, 1'b1, 16'hBEEF, st, dn);
        check("t1_stall_cycles", st, 4);
        check("t1_done_cycle", dn, 5);
        @(negedge clk);
        check("t1_mem_rd_off", mem_rd, 0);
        tick();
        wait_drain("t1");

        // Five back-to-back stores, latency 4, depth 4.
        lat = 4;
        for (int i = 0; i < 5; i++) begin
            do_store(16'h0100 + 16'(2 * i), 16'hA000 + 16'(i), 1'b1, s[i]);
        end
        check("t2_store0_stalls", s[0], 0);
        check("t2_store1_stalls", s[1], 0);
        check("t2_store2_stalls", s[2], 0);
        check("t2_store3_stalls", s[3], 0);
        check("t2_store4_stalls", s[4], 2);
        wait_drain("t2");

        // Store then load of the same address.
        lat = 2;
        do_store(16'h0020, 16'h1234, 1'b1, st);
`ifdef DMEM_WBUF_FWD_EN
        present_load(16'h0020, 1'b0, 16'h1234, st, dn);
        check("t3_done_cycle", dn, 1);
        check("t3_stall_cycles", st, 0);
`else
        present_load(16'h0020, 1'b1, 16'h1234, st, dn);
        check("t3_done_cycle", dn, 7);
        check("t3_stall_cycles", st, 6);
`endif
        wait_drain("t3");

        // Two buffered stores, then halt.
        do_store(16'h0030, 16'h1111, 1'b1, st);
        do_store(16'h0032, 16'h2222, 1'b1, st);
        d0 = dump_cnt;
        do_halt(cyc, un);
        check("t4_halt_out", halt_out, 1);
        check("t4_dump_pulses", dump_cnt - d0, 1);
        check("t4_unstalled", un, 0);
        check("t4_err_out", err_out, 0);
        check("t4_writes_left", exp_wr.size(), 0);
        un       = 0;
        req_rd   = 1'b1;
        req_addr = 16'h0030;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (mem_rd || stall_out || rdata_valid) un++;
            tick();
        end
        req_rd = 1'b0;
        check("t4_req_ignored", un, 0);

        // Load returning an error.
        reset_and_check("rst1");
        lat      = 2;
        err_next = 1'b1;
        mem_model[16'h0040] = 16'h5A5A;
        d0 = dump_cnt;
        present_load(16'h0040, 1'b1, 16'h5A5A, st, dn);
        check("t5_done_cycle", dn, 4);
        repeat (3) tick();
        check("t5_err_out", err_out, 1);
        check("t5_halt_out", halt_out, 1);
        check("t5_no_dump", dump_cnt - d0, 0);

        // Reset during an outstanding load.
        reset_and_check("rst2");
        lat      = 20;
        req_rd   = 1'b1;
        req_addr = 16'h0050;
        tick();
        tick();
        @(negedge clk);
        check("t6_mem_rd_active", mem_rd, 1);
        tick();
        reset_and_check("t6_rst");

        // Reset with stores buffered: buffer must come back empty.
        do_store(16'h0060, 16'h6666, 1'b0, st);
        do_store(16'h0062, 16'h7777, 1'b0, st);
        tick();
        @(negedge clk);
        check("t6b_mem_wr_active", mem_wr, 1);
        tick();
        reset_and_check("t6b_rst");
        lat = 2;
        d0  = dump_cnt;
        do_halt(cyc, un);
        check("t6b_halt_cycles", cyc, 3);
        check("t6b_dump_pulses", dump_cnt - d0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_stage_ctrl.md
Name: dmem_stage_ctrl

Overview:
Parametrised data-memory stage controller between the MEM pipeline stage and the variable-latency data memory/cache system (Rd/Wr/Done/err handshake). It adds a posted store buffer so stores retire without stalling, and tracks a single outstanding load.
It also gates pipeline stall, sequences halt/dump after draining buffered stores, and makes memory errors sticky. It replaces the fixed 16-bit, always-blocking memory stage.

Parameters:
DATA_W, 16, data word width
ADDR_W, 16, byte address width
WBUF_DEPTH, 4, store-buffer entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_rd  in  1  load request from MEM stage (held stable while stall_out=1)
req_wr  in  1  store request (req_rd & req_wr never both 1; bench asserts)
req_addr  in  ADDR_W  load/store address
req_wdata  in  DATA_W  store data
halt_req  in  1  halt/dump instruction reached MEM (held while stall_out=1)
stall_out  out  1  stall MEM and upstream this cycle
rdata  out  DATA_W  load data, valid when rdata_valid=1
rdata_valid  out  1  load completes this cycle
mem_rd  out  1  memory read strobe, held until mem_done
mem_wr  out  1  memory write strobe, held until mem_done
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_rdata  in  DATA_W  memory read data, valid with mem_done
mem_done  in  1  memory access complete (one-cycle pulse)
mem_err  in  1  memory error, sampled with mem_done
dump_out  out  1  one-cycle createdump pulse to memory
halt_out  out  1  sticky: halted or errored
err_out  out  1  sticky memory error

Behaviour:
- One clock; reset synchronous, active-high. Reset: FSM=IDLE, buffer empty (head=tail=count=0), all outputs 0, rdata=0. Reset mid-access drops mem_rd/mem_wr the next edge; the in-flight access is abandoned.
- Store buffer: circular FIFO, count width clog2(WBUF_DEPTH)+1, pointers wrap modulo WBUF_DEPTH.
- Store accepted: req_wr & ~stall_out & ~halt_out; enqueued at tail. stall_out=1 for a store only when count==WBUF_DEPTH. No same-cycle dequeue bypass.
- FSM states: IDLE, LOAD, LOAD_RSP, STORE, DRAIN, DUMP, HALTED.
- IDLE:
  - load presented and issuable -> LOAD; mem_rd=1, mem_addr=req_addr from the next cycle.
  - else buffer non-empty -> STORE; mem_wr=1 with head entry.
  - else halt_req -> DUMP.
- LOAD: hold mem_rd until mem_done; on mem_done capture mem_rdata -> LOAD_RSP.
- LOAD_RSP: rdata_valid=1, stall_out=0 for one cycle -> IDLE.
  - Load latency from acceptance = memory latency + 2 cycles.
  - stall_out=1 every cycle a load is presented except its completion cycle.
- STORE: hold mem_wr until mem_done; then pop head -> IDLE. A new load arriving during STORE waits.
- halt_req: stall_out=1 until halt completes.
  - Buffer non-empty -> DRAIN: retire stores one by one, as in STORE.
  - Buffer empty -> DUMP: dump_out=1 for one cycle -> HALTED.
  - HALTED: halt_out=1, stall_out=0, all requests ignored until rst.
- mem_err=1 with mem_done: err_out=1 and halt_out=1 sticky; pending store is popped; load returns rdata_valid with mem_rdata; FSM -> HALTED without dump.
- mem_done arriving while not in LOAD/STORE/DRAIN: ignored.
- Load issue rule (feature off): a load issues only when count==0. Otherwise the buffer drains first, preserving ordering.

Optional Feature:
DMEM_WBUF_FWD_EN.
- Defined: a load in IDLE CAM-compares req_addr with all valid buffer entries.
  - Hit: youngest matching entry's data returned combinationally the same cycle (rdata_valid=1, stall_out=0, no memory access).
  - Miss: load issues to memory ahead of buffered stores.
- Undefined: load waits for an empty buffer; no compare logic.

Decomposition:
- Package dmem_pkg: FSM state enum; default widths.
- Sub-module dmem_wbuf: FIFO storage, pointers, full/empty, and the forwarding CAM when DMEM_WBUF_FWD_EN is set.
- dmem_stage_ctrl holds the FSM and handshake.

Test Plan:
- Reset then load addr 0x0010; memory done after 3 cycles with data 0xBEEF -> stall_out=1 for 4 cycles, rdata_valid=1 with 0xBEEF in cycle 5; mem_rd deasserts after done.
- 5 back-to-back stores, DEPTH=4, memory latency 4 -> first 4 accepted with no stall; 5th stalls until first pop; memory sees writes in order with correct addr/data.
- Store 0x0020=0x1234, then load 0x0020:
  - FWD_EN: rdata 0x1234 same cycle, no mem_rd.
  - Without: mem_wr completes, then mem_rd, then rdata from memory.
- Two stores buffered, then halt_req -> both writes retire, dump_out pulses exactly once, halt_out=1; later req_rd produces no mem_rd.
- Load with mem_err=1 at done -> err_out=1, halt_out=1, dump_out stays 0.
- rst asserted during LOAD -> next cycle mem_rd=0, state IDLE, buffer empty, outputs zero.
